// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: E/M/W destination tracking with D-stage stall and forwarding selects
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int TW = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [TW-1:0]     tuse_rs_d,
  input  logic [TW-1:0]     tuse_rt_d,
  input  logic              regwrite_d,
  input  logic [REG_AW-1:0] a3_d,
  input  logic [TW-1:0]     tnew_d,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m
);
  logic              r_wr_e, r_wr_m, r_wr_w;
  logic [REG_AW-1:0] r_a3_e, r_a3_m, r_a3_w, r_rs_e, r_rt_e, r_rt_m;
  logic [TW-1:0]     r_tnew_e, r_tnew_m, r_tnew_w;
  function automatic logic [TW-1:0] dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction
  function automatic logic hit(input logic wr, input logic [REG_AW-1:0] a3, input logic [REG_AW-1:0] r);
    return wr && (a3 == r) && (r != '0);
  endfunction
  function automatic logic need_stall(
    input logic [REG_AW-1:0] r, input logic [TW-1:0] tuse,
    input logic we, input logic [REG_AW-1:0] ae, input logic [TW-1:0] te,
    input logic wm, input logic [REG_AW-1:0] am, input logic [TW-1:0] tm);
    return (tuse != '1) && ((hit(we, ae, r) && te > tuse) || (hit(wm, am, r) && tm > tuse));
  endfunction
  // Stall on any not-yet-ready producer; forward from the youngest stage whose result is ready
  always_comb begin
    stall    = need_stall(rs_d, tuse_rs_d, r_wr_e, r_a3_e, r_tnew_e, r_wr_m, r_a3_m, r_tnew_m) ||
               need_stall(rt_d, tuse_rt_d, r_wr_e, r_a3_e, r_tnew_e, r_wr_m, r_a3_m, r_tnew_m);
    fwd_rs_d = (hit(r_wr_e, r_a3_e, rs_d) && r_tnew_e == '0) ? 2'd1 :
               (hit(r_wr_m, r_a3_m, rs_d) && r_tnew_m == '0) ? 2'd2 :
               hit(r_wr_w, r_a3_w, rs_d) ? 2'd3 : 2'd0;
    fwd_rt_d = (hit(r_wr_e, r_a3_e, rt_d) && r_tnew_e == '0) ? 2'd1 :
               (hit(r_wr_m, r_a3_m, rt_d) && r_tnew_m == '0) ? 2'd2 :
               hit(r_wr_w, r_a3_w, rt_d) ? 2'd3 : 2'd0;
    fwd_rs_e = (hit(r_wr_m, r_a3_m, r_rs_e) && r_tnew_m == '0) ? 2'd2 :
               hit(r_wr_w, r_a3_w, r_rs_e) ? 2'd3 : 2'd0;
    fwd_rt_e = (hit(r_wr_m, r_a3_m, r_rt_e) && r_tnew_m == '0) ? 2'd2 :
               hit(r_wr_w, r_a3_w, r_rt_e) ? 2'd3 : 2'd0;
    fwd_rt_m = hit(r_wr_w, r_a3_w, r_rt_m);
  end
  // Advance the in-flight instructions; a stall or reset drops a bubble into E
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {r_wr_e, r_a3_e, r_tnew_e, r_rs_e, r_rt_e} <= '0;
      {r_wr_m, r_a3_m, r_tnew_m, r_rt_m}         <= '0;
      {r_wr_w, r_a3_w, r_tnew_w}                 <= '0;
    end else begin
      if (stall) {r_wr_e, r_a3_e, r_tnew_e, r_rs_e, r_rt_e} <= '0;
      else {r_wr_e, r_a3_e, r_tnew_e, r_rs_e, r_rt_e} <= {regwrite_d && (a3_d != '0), a3_d, dec(tnew_d), rs_d, rt_d};
      {r_wr_m, r_a3_m, r_tnew_m, r_rt_m} <= {r_wr_e, r_a3_e, dec(r_tnew_e), r_rt_e};
      {r_wr_w, r_a3_w, r_tnew_w}         <= {r_wr_m, r_a3_m, dec(r_tnew_m)};
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed hazard scenarios with hand-computed stall/forward expectations
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] rs_d, rt_d, a3_d;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic       regwrite_d;
  logic       stall, fwd_rt_m;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  int checks = 0;
  int failures = 0;
  hazard_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .regwrite_d(regwrite_d),
    .a3_d(a3_d), .tnew_d(tnew_d), .stall(stall), .fwd_rs_d(fwd_rs_d),
    .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] urs,
                       input logic [1:0] urt, input logic wr, input logic [4:0] a3, input logic [1:0] tn);
    rs_d = rs; rt_d = rt; tuse_rs_d = urs; tuse_rt_d = urt; regwrite_d = wr; a3_d = a3; tnew_d = tn;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic nop;
    set_d(0, 0, 3, 3, 0, 0, 0);
  endtask
  task automatic flush;
    nop;
    repeat (3) tick;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {3'b0, stall}, 0);
    chk({tag, "_fwd_rs_d"}, {2'b0, fwd_rs_d}, 0);
    chk({tag, "_fwd_rt_d"}, {2'b0, fwd_rt_d}, 0);
    chk({tag, "_fwd_rs_e"}, {2'b0, fwd_rs_e}, 0);
    chk({tag, "_fwd_rt_e"}, {2'b0, fwd_rt_e}, 0);
    chk({tag, "_fwd_rt_m"}, {3'b0, fwd_rt_m}, 0);
  endtask
  initial begin
    set_d(8, 8, 0, 0, 1, 8, 3);
    repeat (3) tick;
    chk_all_zero("reset");
    nop;
    reset_n = 1'b1;
    flush;
    set_d(29, 0, 1, 3, 1, 8, 3);
    tick;
    set_d(8, 0, 3, 3, 0, 0, 0);
    chk("lw_unused_src_stall", {3'b0, stall}, 0);
    set_d(8, 0, 0, 0, 0, 0, 0);
    chk("lw_beq_stall1", {3'b0, stall}, 1);
    tick;
    chk("lw_beq_stall2", {3'b0, stall}, 1);
    chk("lw_beq_bubble_fwd_rs_e", {2'b0, fwd_rs_e}, 0);
    tick;
    chk("lw_beq_stall_done", {3'b0, stall}, 0);
    chk("lw_beq_fwd_w", {2'b0, fwd_rs_d}, 3);
    flush;
    set_d(1, 2, 1, 1, 1, 9, 2);
    tick;
    set_d(9, 3, 1, 1, 1, 11, 2);
    chk("addu_dep_stall", {3'b0, stall}, 0);
    chk("addu_dep_fwd_rs_d", {2'b0, fwd_rs_d}, 0);
    tick;
    nop;
    chk("addu_dep_fwd_rs_e", {2'b0, fwd_rs_e}, 2);
    chk("addu_dep_fwd_rt_e", {2'b0, fwd_rt_e}, 0);
    flush;
    set_d(0, 0, 3, 3, 1, 31, 0);
    tick;
    set_d(31, 31, 0, 3, 0, 0, 0);
    chk("jal_jr_stall", {3'b0, stall}, 0);
    chk("jal_jr_fwd_rs_d", {2'b0, fwd_rs_d}, 1);
    chk("jal_jr_fwd_rt_d_same", {2'b0, fwd_rt_d}, 1);
    flush;
    set_d(0, 0, 3, 3, 1, 0, 3);
    tick;
    set_d(0, 0, 0, 0, 0, 0, 0);
    chk("zero_reg_stall", {3'b0, stall}, 0);
    chk("zero_reg_fwd_rs_d", {2'b0, fwd_rs_d}, 0);
    flush;
    set_d(1, 2, 1, 1, 1, 10, 2);
    tick;
    set_d(10, 0, 1, 3, 1, 10, 2);
    chk("ori_stall", {3'b0, stall}, 0);
    tick;
    set_d(29, 10, 1, 2, 0, 0, 0);
    chk("sw_d_stall", {3'b0, stall}, 0);
    chk("sw_d_fwd_rt_d", {2'b0, fwd_rt_d}, 2);
    tick;
    nop;
    chk("sw_e_fwd_rt_e_youngest", {2'b0, fwd_rt_e}, 2);
    chk("sw_e_fwd_rs_e", {2'b0, fwd_rs_e}, 0);
    tick;
    chk("sw_m_fwd_rt_m", {3'b0, fwd_rt_m}, 1);
    flush;
    set_d(29, 0, 1, 3, 1, 8, 3);
    tick;
    set_d(8, 8, 0, 0, 0, 0, 0);
    chk("midstall_pre", {3'b0, stall}, 1);
    reset_n = 1'b0;
    tick;
    chk_all_zero("midstall_reset");
    nop;
    reset_n = 1'b1;
    flush;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
